// File: rtl/cpu_pc_pkg.sv
// Shared constants for the next-PC unit: FSM state encodings and default vectors.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pc_pkg;

  // Sequential fetch step in bytes; must be a power of two.
  localparam int unsigned PC_INC = 4;

  // Architectural default vectors.
  localparam logic [31:0] PC_RESET_VEC = 32'h0040_0000;
  localparam logic [31:0] PC_ERR_VEC   = 32'h0000_0004;

  // Redirect-buffer FSM encodings, kept as plain constants for legacy tools.
  typedef logic [1:0] pc_state_t;
  localparam pc_state_t ST_IDLE     = 2'd0;  // nothing buffered
  localparam pc_state_t ST_PEND     = 2'd1;  // branch/jump target buffered
  localparam pc_state_t ST_EXC_PEND = 2'd2;  // exception vector buffered

endpackage

// File: rtl/pc_next_unit_if.sv
// Bundle of next-PC source inputs and PC outputs between the pipeline and pc_next_unit.
// Latency: n/a (wiring only).
// Backpressure: stall is the only hold signal; outputs are always valid.
interface pc_next_unit_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC)
) ();

  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [SEL_W-1:0]         src_sel;
  logic                     stall;
  logic                     exc_req;
  logic [WIDTH-1:0]         exc_vec;
  logic [WIDTH-1:0]         pc;
  logic                     pc_redirect;
  logic                     addr_err;
  logic                     pend_busy;

  // Pipeline side: drives sources and control, observes the PC.
  modport master (
    output src_data, src_sel, stall, exc_req, exc_vec,
    input  pc, pc_redirect, addr_err, pend_busy
  );

  // PC unit side.
  modport slave (
    input  src_data, src_sel, stall, exc_req, exc_vec,
    output pc, pc_redirect, addr_err, pend_busy
  );

endinterface

// File: rtl/pc_src_mux.sv
// Combinational NUM_SRC x WIDTH selector; any select outside 1..NUM_SRC-1 returns slice 0.
// Latency: zero cycles (pure combinational).
// Backpressure: none.
module pc_src_mux #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC*WIDTH-1:0] src_dat,
  input  logic [SEL_W-1:0]         src_sel,
  output logic [WIDTH-1:0]         sel_dat
);

  // Default to slice 0 so out-of-range selects fall back deterministically.
  always_comb begin
    sel_dat = src_dat[WIDTH-1:0];
    for (int i = 1; i < NUM_SRC; i++) begin
      if (32'(src_sel) == i) begin
        sel_dat = src_dat[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// Registered next-PC generator with stall hold, redirect/exception buffering and misaligned-target trap.
// Latency: one cycle from select to pc; a buffered target lands on the first unstalled edge.
// Backpressure: stall freezes pc; the first redirect (or latest exception) seen during a stall is buffered.
module pc_next_unit
  import cpu_pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               NUM_SRC   = 4,
  parameter int               SEL_W     = $clog2(NUM_SRC),
  parameter int               INC       = PC_INC,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
  parameter logic [WIDTH-1:0] ERR_VEC   = WIDTH'(PC_ERR_VEC)
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_next_unit_if.slave bus
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
  pc_state_t        state_q, state_d;
  logic             redirect_q, redirect_d;
  logic             addr_err_q, addr_err_d;

  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] pc_seq;
  logic             is_seq;
  logic             misal;

  pc_src_mux #(
    .WIDTH   (WIDTH),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_src_mux (
    .src_dat (bus.src_data),
    .src_sel (bus.src_sel),
    .sel_dat (tgt)
  );

  // Source classification: select 0 and out-of-range selects both mean "fall through".
  always_comb begin
    pc_seq = pc_q + WIDTH'(INC);
    is_seq = (bus.src_sel == '0) || (32'(bus.src_sel) >= 32'(NUM_SRC));
    misal  = |(tgt & WIDTH'(INC - 1));
  end

  // Next-state: exceptions beat buffered redirects, which beat fresh selects.
  always_comb begin
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    state_d    = state_q;
    redirect_d = 1'b0;
    addr_err_d = 1'b0;
    if (!bus.stall) begin
      if (bus.exc_req) begin
        pc_d       = bus.exc_vec;
        redirect_d = 1'b1;
        state_d    = ST_IDLE;
      end else if (state_q != ST_IDLE) begin
        pc_d       = pend_pc_q;
        redirect_d = 1'b1;
        state_d    = ST_IDLE;
      end else if (!is_seq && !misal) begin
        pc_d       = tgt;
        redirect_d = 1'b1;
      end else if (!is_seq) begin
        pc_d       = ERR_VEC;
        redirect_d = 1'b1;
        addr_err_d = 1'b1;
      end else begin
        pc_d       = pc_seq;
      end
    end else begin
      if (bus.exc_req) begin
        pend_pc_d = bus.exc_vec;
        state_d   = ST_EXC_PEND;
      end else if (!is_seq && (state_q == ST_IDLE)) begin
        pend_pc_d  = misal ? ERR_VEC : tgt;
        addr_err_d = misal;
        state_d    = ST_PEND;
      end
    end
  end

  // PC, buffer and event-pulse registers; reset drops any buffered target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_VEC;
      pend_pc_q  <= '0;
      state_q    <= ST_IDLE;
      redirect_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      state_q    <= state_d;
      redirect_q <= redirect_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Output drive straight from state.
  always_comb begin
    bus.pc          = pc_q;
    bus.pc_redirect = redirect_q;
    bus.addr_err    = addr_err_q;
    bus.pend_busy   = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed scoreboard bench for pc_next_unit (select width widened to 3 to reach out-of-range selects).
module tb_pc_next_unit;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        redir;
    logic        aerr;
    logic        busy;
  } exp_t;

  exp_t sb[$];

  pc_next_unit_if #(.WIDTH(32), .NUM_SRC(4), .SEL_W(3)) bus ();

  pc_next_unit #(.WIDTH(32), .NUM_SRC(4), .SEL_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] pc, input logic r,
                      input logic a, input logic b);
    exp_t e;
    e.tag = tag; e.pc = pc; e.redir = r; e.aerr = a; e.busy = b;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".pc"},    bus.pc,                  e.pc);
      chk({e.tag, ".redir"}, {31'd0, bus.pc_redirect}, {31'd0, e.redir});
      chk({e.tag, ".aerr"},  {31'd0, bus.addr_err},    {31'd0, e.aerr});
      chk({e.tag, ".busy"},  {31'd0, bus.pend_busy},   {31'd0, e.busy});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic drive(input logic st, input logic [2:0] sel, input logic ex,
                       input logic [31:0] ev);
    bus.stall   = st;
    bus.src_sel = sel;
    bus.exc_req = ex;
    bus.exc_vec = ev;
  endtask

  task automatic set_slice(input int i, input logic [31:0] v);
    bus.src_data[i*32 +: 32] = v;
  endtask

  initial begin
    rst_n        = 1'b1;
    bus.src_data = '0;
    drive(1'b0, 3'd0, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #2;
    push("reset", 32'h0040_0000, 1'b0, 1'b0, 1'b0);
    check_out();
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch after reset.
    push("seq1", 32'h0040_0004, 1'b0, 1'b0, 1'b0); tick();
    push("seq2", 32'h0040_0008, 1'b0, 1'b0, 1'b0); tick();
    push("seq3", 32'h0040_000C, 1'b0, 1'b0, 1'b0); tick();
    push("seq4", 32'h0040_0010, 1'b0, 1'b0, 1'b0); tick();

    // Aligned redirect, then a misaligned one.
    set_slice(2, 32'h0040_0100); drive(1'b0, 3'd2, 1'b0, 32'h0);
    push("jmp", 32'h0040_0100, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 3'd0, 1'b0, 32'h0);
    push("jmp_after", 32'h0040_0104, 1'b0, 1'b0, 1'b0); tick();
    set_slice(3, 32'h0040_0102); drive(1'b0, 3'd3, 1'b0, 32'h0);
    push("misal", 32'h0000_0004, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b0, 3'd0, 1'b0, 32'h0);
    push("misal_after", 32'h0000_0008, 1'b0, 1'b0, 1'b0); tick();

    // Stall buffering: first redirect wins.
    set_slice(1, 32'h0040_0200); drive(1'b1, 3'd1, 1'b0, 32'h0);
    push("stall_buf", 32'h0000_0008, 1'b0, 1'b0, 1'b1); tick();
    set_slice(2, 32'h0040_0300); drive(1'b1, 3'd2, 1'b0, 32'h0);
    push("stall_2nd", 32'h0000_0008, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b1, 3'd0, 1'b0, 32'h0);
    push("stall_hold", 32'h0000_0008, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b0, 3'd0, 1'b0, 32'h0);
    push("stall_rel", 32'h0040_0200, 1'b1, 1'b0, 1'b0); tick();
    push("stall_seq", 32'h0040_0204, 1'b0, 1'b0, 1'b0); tick();

    // Exception overrides a buffered redirect and is not displaced by a later one.
    set_slice(1, 32'h0040_0400); drive(1'b1, 3'd1, 1'b0, 32'h0);
    push("pend", 32'h0040_0204, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b1, 3'd0, 1'b1, 32'h8000_0180);
    push("exc_over", 32'h0040_0204, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b1, 3'd1, 1'b0, 32'h0);
    push("exc_keep", 32'h0040_0204, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b0, 3'd0, 1'b0, 32'h0);
    push("exc_rel", 32'h8000_0180, 1'b1, 1'b0, 1'b0); tick();
    push("exc_seq", 32'h8000_0184, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 3'd1, 1'b1, 32'h8000_0180);
    push("exc_vs_sel", 32'h8000_0180, 1'b1, 1'b0, 1'b0); tick();

    // Stalled exception with a misaligned select: no addr_err.
    drive(1'b1, 3'd3, 1'b1, 32'h8000_0300);
    push("exc_misal", 32'h8000_0180, 1'b0, 1'b0, 1'b1); tick();
    // A later exception overwrites the buffered one.
    drive(1'b1, 3'd0, 1'b1, 32'h8000_0400);
    push("exc_ovw", 32'h8000_0180, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b0, 3'd0, 1'b0, 32'h0);
    push("exc_ovw_rel", 32'h8000_0400, 1'b1, 1'b0, 1'b0); tick();

    // Misaligned select while stalled and idle: trap flagged on capture edge.
    drive(1'b1, 3'd3, 1'b0, 32'h0);
    push("st_misal", 32'h8000_0400, 1'b0, 1'b1, 1'b1); tick();
    drive(1'b0, 3'd0, 1'b0, 32'h0);
    push("st_misal_rel", 32'h0000_0004, 1'b1, 1'b0, 1'b0); tick();

    // Wrap and out-of-range selects.
    set_slice(2, 32'hFFFF_FFFC); drive(1'b0, 3'd2, 1'b0, 32'h0);
    push("to_top", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 3'd0, 1'b0, 32'h0);
    push("wrap", 32'h0000_0000, 1'b0, 1'b0, 1'b0); tick();
    set_slice(0, 32'h1234_5679);
    drive(1'b0, 3'd5, 1'b0, 32'h0);
    push("oor5", 32'h0000_0004, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 3'd7, 1'b0, 32'h0);
    push("oor7", 32'h0000_0008, 1'b0, 1'b0, 1'b0); tick();

    // Async reset while a redirect is buffered.
    set_slice(1, 32'h0040_0500); drive(1'b1, 3'd1, 1'b0, 32'h0);
    push("pre_rst", 32'h0000_0008, 1'b0, 1'b0, 1'b1); tick();
    #2 rst_n = 1'b0;
    #1;
    push("mid_rst", 32'h0040_0000, 1'b0, 1'b0, 1'b0);
    check_out();
    drive(1'b0, 3'd0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    push("post_rst1", 32'h0040_0004, 1'b0, 1'b0, 1'b0); tick();
    push("post_rst2", 32'h0040_0008, 1'b0, 1'b0, 1'b0); tick();

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_drain: observed %0d leftover expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
Registered next-PC generator for the 54-instruction pipeline. It generalises the fixed 4-way PC-source select into NUM_SRC parametrised sources and owns the PC register. The sequential increment is computed internally. On top of selection it adds stall hold, redirect buffering across stalls, exception priority and misaligned-target trapping. It feeds instruction-fetch address and the PC+INC path.

Parameters:
WIDTH, 32, PC/address width
NUM_SRC, 4, number of PC sources including sequential source 0
SEL_W, $clog2(NUM_SRC), width of src_sel
INC, 4, sequential increment in bytes (power of two)
RESET_VEC, 32'h0040_0000, PC value after reset
ERR_VEC, 32'h0000_0004, PC loaded on misaligned target

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
src_data  in  NUM_SRC*WIDTH  flattened targets; slice i = source i; slice 0 ignored (sequential is internal)
src_sel  in  SEL_W  source select; 0 = sequential
stall  in  1  hold PC this cycle
exc_req  in  1  exception request, single-cycle
exc_vec  in  WIDTH  exception handler address, valid with exc_req
pc  out  WIDTH  current PC (registered)
pc_redirect  out  1  1-cycle pulse: pc was loaded from a non-sequential value
addr_err  out  1  1-cycle pulse: a misaligned target was trapped
pend_busy  out  1  a redirect or exception is buffered (state != IDLE)

Behaviour:
- Reset (async, rst_n=0): pc=RESET_VEC; pc_redirect=0; addr_err=0; pend_busy=0; pend_pc=0; state=IDLE. Reset mid-stall or mid-pending discards the buffered target.
- State machine: IDLE, PEND (branch/jump buffered), EXC_PEND (exception buffered). pend_busy = (state != IDLE).
- Target selection: tgt = src_data slice src_sel. If src_sel is 0 or src_sel >= NUM_SRC, the source is sequential: pc + INC, modulo 2^WIDTH (wraps, no flag).
- Misalignment: a non-sequential tgt is misaligned when any of its low log2(INC) bits is non-zero. Exception vectors are never checked.
- Not stalled (stall=0). Priority on the next edge, highest first:
  1. exc_req: pc<=exc_vec, pc_redirect=1, state->IDLE.
  2. state EXC_PEND or PEND: pc<=pend_pc, pc_redirect=1, state->IDLE. A concurrent src_sel is dropped.
  3. src_sel non-sequential and aligned: pc<=tgt, pc_redirect=1.
  4. src_sel non-sequential and misaligned: pc<=ERR_VEC, pc_redirect=1, addr_err=1.
  5. Otherwise: pc<=pc+INC, pc_redirect=0.
- Stalled (stall=1): pc holds and pc_redirect=0.
  - exc_req: pend_pc<=exc_vec, state->EXC_PEND. This overrides PEND and overwrites a prior EXC_PEND.
  - Non-sequential src_sel while IDLE: pend_pc<=tgt, or ERR_VEC if misaligned with addr_err=1 on that edge; state->PEND.
  - Non-sequential src_sel while PEND or EXC_PEND: ignored (first redirect wins; exceptions are never displaced by redirects).
  - Same-cycle exc_req and src_sel: exc_req wins; addr_err is not raised.
- Latency: one cycle from select to pc. A buffered target appears on pc on the first edge with stall=0.
- pc_redirect and addr_err are registered and are high for exactly one cycle per event.

Decomposition:
- Shared package cpu_pc_pkg holds: the state enum (IDLE/PEND/EXC_PEND), RESET_VEC and ERR_VEC defaults, and the INC constant.
- One sub-module is natural: pc_src_mux, a purely combinational parametrised NUM_SRC×WIDTH selector with out-of-range select mapping to slice 0. Instantiate it once.
- The FSM, PC register and alignment check stay in pc_next_unit.

Test Plan:
1. Reset release with src_sel=0 for 3 cycles -> pc 0x00400000, 0x00400004, 0x00400008, 0x0040000C; pc_redirect=0 throughout.
2. pc=0x00400010, src_sel=2, slice2=0x00400100 -> next pc=0x00400100, pc_redirect=1 for one cycle; src_sel=3 with slice3=0x00400102 -> pc=0x00000004, addr_err=1 for one cycle.
3. stall=1, src_sel=1 with slice1=0x00400200, then src_sel=2 with a different target during the stall, stall held 3 cycles -> pc holds, pend_busy=1, second redirect ignored; after release pc=0x00400200, pend_busy=0.
4. During stall with PEND active, exc_req=1 with exc_vec=0x80000180 -> state EXC_PEND; after release pc=0x80000180. Repeat with exc_req and src_sel=1 on the same unstalled edge -> pc=0x80000180.
5. pc=0xFFFFFFFC, src_sel=0 -> pc=0x00000000, no addr_err. With NUM_SRC=4, force src_sel out of range (width override 3, sel=5) -> sequential behaviour.
6. Assert rst_n=0 asynchronously mid-clock while pend_busy=1 -> pc=0x00400000 immediately, pend_busy=0; after release the buffered target is never applied.
